// File: rtl/debug_halt_ctrl.sv
// Run-control sequencer: halts and drains the pipeline on debugger request, then
// lends the data-memory port to a debug requester for single-word peek/poke.
module debug_halt_ctrl #(
  parameter int DATA_W       = 32,
  parameter int DM_ADDRESS   = 9,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_RD_LAT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt_req,
  input  logic                  i_resume_req,
  input  logic                  i_pc_sel,
  output logic                  o_halt,
  output logic                  o_fetch_flush,
  output logic                  o_halted,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [DM_ADDRESS-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0]     i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic [DATA_W-1:0]     o_dbg_rdata,
  output logic                  o_dbg_err,
  input  logic                  i_cpu_rd,
  input  logic                  i_cpu_wr,
  input  logic [DM_ADDRESS-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0]     i_cpu_wdata,
  input  logic [2:0]            i_cpu_func3,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [DM_ADDRESS-1:0] o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [2:0]            o_mem_func3,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int CNT_MAX = (DRAIN_CYCLES > MEM_RD_LAT) ? DRAIN_CYCLES : MEM_RD_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(MEM_RD_LAT - 1);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_HALTED, S_DBG_ACC, S_DBG_WAIT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_dbg_rdata;
  logic               w_cnt_zero;
  logic               w_rd_done;
  logic               w_own_mem;

  assign w_cnt_zero = (r_cnt == '0);
  // Gated by reset so an access interrupted by reset never acknowledges.
  assign w_rd_done  = (r_state == S_DBG_WAIT) && w_cnt_zero && i_reset;
  assign w_own_mem  = (r_state == S_HALTED) || (r_state == S_DBG_ACC) || (r_state == S_DBG_WAIT);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_halt_req) begin
            r_state <= S_DRAIN;
            r_cnt   <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          // A taken branch refills the pipe, so the drain window restarts.
          if (i_pc_sel)        r_cnt   <= DRAIN_LOAD;
          else if (w_cnt_zero) r_state <= S_HALTED;
          else                 r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_HALTED: begin
          if (i_dbg_req)         r_state <= S_DBG_ACC;
          else if (i_resume_req) r_state <= S_RUN;
        end
        S_DBG_ACC: begin
          if (i_dbg_we) begin
            r_state <= S_HALTED;
          end else begin
            r_state <= S_DBG_WAIT;
            r_cnt   <= WAIT_LOAD;
          end
        end
        S_DBG_WAIT: begin
          if (w_cnt_zero) begin
            r_dbg_rdata <= i_mem_rdata;
            r_state     <= S_HALTED;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    o_halt        = w_own_mem || ((r_state == S_DRAIN) && !i_pc_sel);
    o_fetch_flush = (r_state != S_RUN);
    o_halted      = w_own_mem;
    o_dbg_err     = i_dbg_req && ((r_state == S_RUN) || (r_state == S_DRAIN));
    o_dbg_ack     = ((r_state == S_DBG_ACC) && i_dbg_we && i_reset) || w_rd_done;
    // Read data is forwarded in the ack cycle and held in r_dbg_rdata afterwards.
    o_dbg_rdata   = w_rd_done ? i_mem_rdata : r_dbg_rdata;

    o_mem_rd    = i_cpu_rd;
    o_mem_wr    = i_cpu_wr;
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_func3 = i_cpu_func3;
    case (r_state)
      S_HALTED: begin
        o_mem_rd = 1'b0;
        o_mem_wr = 1'b0;
      end
      S_DBG_ACC, S_DBG_WAIT: begin
        o_mem_rd    = (r_state == S_DBG_WAIT) || !i_dbg_we;
        o_mem_wr    = (r_state == S_DBG_ACC) && i_dbg_we && i_reset;
        o_mem_addr  = i_dbg_addr;
        o_mem_wdata = i_dbg_wdata;
        o_mem_func3 = 3'b010;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Randomized bench for debug_halt_ctrl, checked against a mode/latency model
// and a word-addressed data-memory stand-in with one cycle of read latency.
module tb_debug_halt_ctrl;
  localparam int DATA_W = 32;
  localparam int AW     = 9;
  localparam int DRAIN  = 4;
  localparam int LAT    = 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_ACC = 3;

  logic clk = 1'b0;
  logic reset, halt_req, resume_req, pc_sel;
  logic halt, fetch_flush, halted;
  logic dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [AW-1:0] dbg_addr, cpu_addr, mem_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata, cpu_wdata, mem_wdata, mem_rdata;
  logic cpu_rd, cpu_wr, mem_rd, mem_wr;
  logic [2:0] cpu_func3, mem_func3;

  logic [DATA_W-1:0] sim_mem [512];
  logic [DATA_W-1:0] m_mem   [512];

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;
  int n_rst_wait = 0;

  int  m_mode = M_RUN;
  int  m_quiet, m_age;
  bit  m_we, m_ack_now, pend;
  logic [AW-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_last;

  always #5 clk = ~clk;

  debug_halt_ctrl #(.DATA_W(DATA_W), .DM_ADDRESS(AW), .DRAIN_CYCLES(DRAIN), .MEM_RD_LAT(LAT)) dut (
    .i_clk(clk), .i_reset(reset), .i_halt_req(halt_req), .i_resume_req(resume_req),
    .i_pc_sel(pc_sel), .o_halt(halt), .o_fetch_flush(fetch_flush), .o_halted(halted),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata), .o_dbg_err(dbg_err),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_func3(cpu_func3), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_func3(mem_func3), .i_mem_rdata(mem_rdata)
  );

  // Data memory with a registered read port.
  always @(posedge clk) begin
    if (mem_wr === 1'b1) sim_mem[mem_addr] <= mem_wdata;
    mem_rdata <= sim_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs of the cycle that ended.
  task automatic model_step();
    bit done;
    if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      if (cpu_wr) m_mem[cpu_addr] = cpu_wdata;
    end else if (m_mode == M_ACC && reset) begin
      if (m_we && m_age == 1) m_mem[m_addr] = m_wdata;
      if (!m_we && m_age == LAT + 1) m_last = m_mem[m_addr];
    end
    if (!reset) begin
      m_mode = M_RUN; m_last = '0; m_quiet = 0;
    end else begin
      case (m_mode)
        M_RUN: if (halt_req) begin m_mode = M_DRAIN; m_quiet = 0; end
        M_DRAIN: begin
          m_quiet = pc_sel ? 0 : m_quiet + 1;
          if (m_quiet == DRAIN) m_mode = M_HALT;
        end
        M_HALT: begin
          if (dbg_req) begin
            m_mode = M_ACC; m_age = 1;
            m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
          end else if (resume_req) m_mode = M_RUN;
        end
        default: begin
          done = m_we ? (m_age == 1) : (m_age == LAT + 1);
          if (done) m_mode = M_HALT;
          else m_age++;
        end
      endcase
    end
  endtask

  task automatic drive();
    int r;
    reset = ($urandom_range(0, 99) != 0);
    if (m_mode == M_ACC && !m_we && m_age == LAT + 1 && $urandom_range(0, 3) == 0) begin
      reset = 1'b0;
      n_rst_wait++;
    end
    if (pend && m_mode != M_ACC && m_mode != M_HALT) pend = 0;
    r = $urandom_range(0, 3);
    cpu_rd    = (r == 1);
    cpu_wr    = (r == 2);
    cpu_addr  = AW'($urandom_range(0, 15) * 4);
    cpu_wdata = $urandom;
    cpu_func3 = 3'($urandom_range(0, 7));
    pc_sel    = ($urandom_range(0, 3) == 0);
    halt_req  = ($urandom_range(0, 7) == 0);
    resume_req = ($urandom_range(0, 3) == 0);
    if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      dbg_req   = ($urandom_range(0, 9) == 0);
      dbg_we    = $urandom_range(0, 1);
      dbg_addr  = AW'($urandom_range(0, 15) * 4);
      dbg_wdata = $urandom;
    end else if (m_mode == M_HALT && !pend) begin
      if ($urandom_range(0, 1) == 1) begin
        pend      = 1;
        dbg_req   = 1'b1;
        dbg_we    = $urandom_range(0, 1);
        dbg_addr  = AW'($urandom_range(0, 15) * 4);
        dbg_wdata = $urandom;
      end else dbg_req = 1'b0;
    end
  endtask

  task automatic check();
    bit own, pass, ack;
    logic [DATA_W-1:0] rdat;
    own  = (m_mode == M_HALT || m_mode == M_ACC);
    pass = (m_mode == M_RUN || m_mode == M_DRAIN);
    ack  = 0;
    rdat = m_last;
    if (m_mode == M_ACC && reset) begin
      if (m_we && m_age == 1) ack = 1;
      if (!m_we && m_age == LAT + 1) begin ack = 1; rdat = m_mem[m_addr]; end
    end
    m_ack_now = ack;
    chk("halt", halt, own || (m_mode == M_DRAIN && !pc_sel));
    chk("fetch_flush", fetch_flush, m_mode != M_RUN);
    chk("halted", halted, own);
    chk("dbg_err", dbg_err, pass && dbg_req);
    chk("dbg_ack", dbg_ack, ack);
    chk("dbg_rdata", dbg_rdata, rdat);
    if (pass) begin
      chk("mem_rd_pass", mem_rd, cpu_rd);
      chk("mem_wr_pass", mem_wr, cpu_wr);
      chk("mem_addr_pass", mem_addr, cpu_addr);
      chk("mem_wdata_pass", mem_wdata, cpu_wdata);
      chk("mem_func3_pass", mem_func3, cpu_func3);
    end else if (m_mode == M_HALT) begin
      chk("mem_rd_halt", mem_rd, 0);
      chk("mem_wr_halt", mem_wr, 0);
    end else begin
      chk("mem_rd_dbg", mem_rd, !m_we);
      chk("mem_wr_dbg", mem_wr, m_we && m_age == 1 && reset);
      if (m_age == 1) begin
        chk("mem_addr_dbg", mem_addr, m_addr);
        chk("mem_func3_dbg", mem_func3, 3'b010);
        if (m_we) chk("mem_wdata_dbg", mem_wdata, m_wdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin sim_mem[i] = '0; m_mem[i] = '0; end
    m_last = '0; m_quiet = 0; m_age = 0; pend = 0;
    reset = 1'b0; halt_req = 0; resume_req = 0; pc_sel = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_func3 = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); model_step();
      @(negedge clk); check();
    end
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); model_step();
      #1 drive();
      @(negedge clk); check();
      if (pend && m_ack_now) begin
        pend = 0; dbg_req = 1'b0; n_acks++;
      end
    end
    chk("acks_seen", n_acks > 20, 1);
    chk("reset_in_wait_seen", n_rst_wait > 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
